// File: rtl/res_mgr_pkg.sv
// Shared resource-manager definitions: source encoding, id widths and request record.
// Host/plane counts come from `MAX_HOST_NUMBER / `MAX_PLANE_NUMBER; the defaults below apply when they are not set.
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 8
`endif

package res_mgr_pkg;
    localparam int NO_OF_SOURCES    = 2;
    localparam int SOURCE_BIT_WIDTH = $clog2(NO_OF_SOURCES);

    localparam logic [SOURCE_BIT_WIDTH-1:0] SOURCE_FTL = SOURCE_BIT_WIDTH'(0);
    localparam logic [SOURCE_BIT_WIDTH-1:0] SOURCE_FMC = SOURCE_BIT_WIDTH'(1);

    localparam int MAX_HOST_NUMBER    = `MAX_HOST_NUMBER;
    localparam int MAX_PLANE_NUMBER   = `MAX_PLANE_NUMBER;
    localparam int HOST_ID_BIT_WIDTH  = $clog2(MAX_HOST_NUMBER);
    localparam int PLANE_ID_BIT_WIDTH = $clog2(MAX_PLANE_NUMBER);

    typedef struct packed {
        logic [HOST_ID_BIT_WIDTH-1:0]  host_id;
        logic [PLANE_ID_BIT_WIDTH-1:0] plane_id;
    } res_req_t;
endpackage

// File: rtl/res_req_fifo.sv
// Synchronous request FIFO with registered occupancy; full/empty are decoded from the level register.
// Pushes while full and pops while empty are ignored.
module res_req_fifo #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 8,
    localparam int LEVEL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (o_level == LEVEL_W'(DEPTH));
    assign o_empty = (o_level == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   o_level <= o_level + LEVEL_W'(1);
                2'b01:   o_level <= o_level - LEVEL_W'(1);
                default: o_level <= o_level;
            endcase
        end
    end
endmodule

// File: rtl/resource_req_arbiter.sv
// Buffers FTL/FMC resource requests and arbitrates them onto one valid/ready port toward the bitmap manager.
// Define RES_ARB_FMC_PRIORITY_EN for FMC priority with FTL anti-starvation; otherwise round-robin.
module resource_req_arbiter
    import res_mgr_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ftl_valid,
    output logic                          o_ftl_ready,
    input  logic [HOST_ID_BIT_WIDTH-1:0]  i_ftl_host_id,
    input  logic [PLANE_ID_BIT_WIDTH-1:0] i_ftl_plane_id,
    input  logic                          i_fmc_valid,
    output logic                          o_fmc_ready,
    input  logic [HOST_ID_BIT_WIDTH-1:0]  i_fmc_host_id,
    input  logic [PLANE_ID_BIT_WIDTH-1:0] i_fmc_plane_id,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [HOST_ID_BIT_WIDTH-1:0]  o_host_id,
    output logic [PLANE_ID_BIT_WIDTH-1:0] o_plane_id,
    output logic [SOURCE_BIT_WIDTH-1:0]   o_source,
    output logic [LEVEL_W-1:0]            o_ftl_level,
    output logic [LEVEL_W-1:0]            o_fmc_level
);
    typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("resource_req_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    state_t   state;
    res_req_t ftl_din, fmc_din, ftl_dout, fmc_dout, win_req;
    logic     ftl_full, ftl_empty, fmc_full, fmc_empty;
    logic     ftl_push, fmc_push, ftl_pop, fmc_pop;
    logic     load, grant_fmc;

    assign ftl_din     = '{host_id: i_ftl_host_id, plane_id: i_ftl_plane_id};
    assign fmc_din     = '{host_id: i_fmc_host_id, plane_id: i_fmc_plane_id};
    assign o_ftl_ready = !ftl_full;
    assign o_fmc_ready = !fmc_full;
    assign ftl_push    = i_ftl_valid && !ftl_full;
    assign fmc_push    = i_fmc_valid && !fmc_full;

    res_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(res_req_t))) u_ftl_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (ftl_push),
        .i_data  (ftl_din),
        .i_pop   (ftl_pop),
        .o_data  (ftl_dout),
        .o_full  (ftl_full),
        .o_empty (ftl_empty),
        .o_level (o_ftl_level)
    );

    res_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(res_req_t))) u_fmc_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fmc_push),
        .i_data  (fmc_din),
        .i_pop   (fmc_pop),
        .o_data  (fmc_dout),
        .o_full  (fmc_full),
        .o_empty (fmc_empty),
        .o_level (o_fmc_level)
    );

`ifdef RES_ARB_FMC_PRIORITY_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    // FMC frees resources so it normally wins; FTL is forced in after STARVE_LIMIT back-to-back FMC grants
    always_comb begin
        grant_fmc = 1'b0;
        if (!fmc_empty) begin
            grant_fmc = ftl_empty || (starve_cnt != STARVE_W'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (ftl_empty || (load && !grant_fmc)) begin
            starve_cnt <= '0;
        end else if (load) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    logic [SOURCE_BIT_WIDTH-1:0] rr_last;

    always_comb begin
        grant_fmc = 1'b0;
        if (!fmc_empty) begin
            grant_fmc = ftl_empty || (rr_last == SOURCE_FTL);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_last <= SOURCE_FMC;
        end else if (load) begin
            rr_last <= grant_fmc ? SOURCE_FMC : SOURCE_FTL;
        end
    end
`endif

    // The output register can take a new request when empty or when the manager accepts the held one
    assign load    = (!ftl_empty || !fmc_empty) && (state == ST_EMPTY || i_ready);
    assign ftl_pop = load && !grant_fmc;
    assign fmc_pop = load && grant_fmc;
    assign win_req = grant_fmc ? fmc_dout : ftl_dout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_EMPTY;
            o_valid    <= 1'b0;
            o_host_id  <= '0;
            o_plane_id <= '0;
            o_source   <= SOURCE_FTL;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state      <= ST_HOLD;
                        o_valid    <= 1'b1;
                        o_host_id  <= win_req.host_id;
                        o_plane_id <= win_req.plane_id;
                        o_source   <= grant_fmc ? SOURCE_FMC : SOURCE_FTL;
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        if (load) begin
                            o_host_id  <= win_req.host_id;
                            o_plane_id <= win_req.plane_id;
                            o_source   <= grant_fmc ? SOURCE_FMC : SOURCE_FTL;
                        end else begin
                            state   <= ST_EMPTY;
                            o_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_resource_req_arbiter.sv
// Self-checking bench for resource_req_arbiter: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_resource_req_arbiter;
    import res_mgr_pkg::*;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          ftl_valid, fmc_valid, rdy;
    logic [HOST_ID_BIT_WIDTH-1:0]  ftl_host, fmc_host;
    logic [PLANE_ID_BIT_WIDTH-1:0] ftl_plane, fmc_plane;
    logic                          ftl_ready, fmc_ready, out_valid;
    logic [HOST_ID_BIT_WIDTH-1:0]  out_host;
    logic [PLANE_ID_BIT_WIDTH-1:0] out_plane;
    logic [SOURCE_BIT_WIDTH-1:0]   out_source;
    logic [LEVEL_W-1:0]            ftl_level, fmc_level;

    int checks = 0;
    int errors = 0;

    resource_req_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ftl_valid    (ftl_valid),
        .o_ftl_ready    (ftl_ready),
        .i_ftl_host_id  (ftl_host),
        .i_ftl_plane_id (ftl_plane),
        .i_fmc_valid    (fmc_valid),
        .o_fmc_ready    (fmc_ready),
        .i_fmc_host_id  (fmc_host),
        .i_fmc_plane_id (fmc_plane),
        .o_valid        (out_valid),
        .i_ready        (rdy),
        .o_host_id      (out_host),
        .o_plane_id     (out_plane),
        .o_source       (out_source),
        .o_ftl_level    (ftl_level),
        .o_fmc_level    (fmc_level)
    );

    always #5 clk = ~clk;

    // Reference model: two request queues plus the one-entry output slot
    typedef struct { int host; int plane; } mreq_t;
    mreq_t ftl_q[$];
    mreq_t fmc_q[$];
    bit    m_valid;
    int    m_host, m_plane, m_src, m_last_src, m_fmc_streak;

    typedef struct {
        bit rst_before;
        bit fv; int fh; int fp;
        bit mv; int mh; int mp;
        bit rd;
        bit ev; int eh; int ep; int es; int efl; int eml;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit rb, bit fv, int fh, int fp, bit mv, int mh, int mp, bit rd,
                                bit ev, int eh, int ep, int es, int efl, int eml);
        vec_t v;
        v.rst_before = rb; v.fv = fv; v.fh = fh; v.fp = fp; v.mv = mv; v.mh = mh; v.mp = mp; v.rd = rd;
        v.ev = ev; v.eh = eh; v.ep = ep; v.es = es; v.efl = efl; v.eml = eml;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    function automatic void modelClear();
        ftl_q.delete();
        fmc_q.delete();
        m_valid = 0; m_host = 0; m_plane = 0; m_src = 0;
        m_last_src = 1; m_fmc_streak = 0;
    endfunction

    // 0 = FTL, 1 = FMC
    function automatic int pickSource();
        if (ftl_q.size() == 0) return 1;
        if (fmc_q.size() == 0) return 0;
`ifdef RES_ARB_FMC_PRIORITY_EN
        return (m_fmc_streak >= STARVE_LIMIT) ? 0 : 1;
`else
        return (m_last_src == 0) ? 1 : 0;
`endif
    endfunction

    task automatic modelStep();
        bit    ftl_can, fmc_can, ftl_was_empty;
        int    src;
        mreq_t r;
        ftl_can       = ftl_q.size() < FIFO_DEPTH;
        fmc_can       = fmc_q.size() < FIFO_DEPTH;
        ftl_was_empty = (ftl_q.size() == 0);
        if ((!m_valid || rdy) && (ftl_q.size() > 0 || fmc_q.size() > 0)) begin
            src = pickSource();
            if (src == 0) r = ftl_q.pop_front();
            else          r = fmc_q.pop_front();
            m_valid = 1; m_host = r.host; m_plane = r.plane; m_src = src; m_last_src = src;
            if (src == 0) m_fmc_streak = 0;
            else          m_fmc_streak = m_fmc_streak + 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (ftl_was_empty) m_fmc_streak = 0;
        if (ftl_valid && ftl_can) ftl_q.push_back('{host: int'(ftl_host), plane: int'(ftl_plane)});
        if (fmc_valid && fmc_can) fmc_q.push_back('{host: int'(fmc_host), plane: int'(fmc_plane)});
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".valid"}, out_valid, m_valid);
        if (m_valid) begin
            checkOutput({tag, ".host"}, out_host, m_host);
            checkOutput({tag, ".plane"}, out_plane, m_plane);
            checkOutput({tag, ".source"}, out_source, m_src);
        end
        checkOutput({tag, ".ftl_level"}, ftl_level, ftl_q.size());
        checkOutput({tag, ".fmc_level"}, fmc_level, fmc_q.size());
        checkOutput({tag, ".ftl_ready"}, ftl_ready, ftl_q.size() < FIFO_DEPTH);
        checkOutput({tag, ".fmc_ready"}, fmc_ready, fmc_q.size() < FIFO_DEPTH);
    endtask

    task automatic applyStimulus(input bit fv, input int fh, input int fp,
                                 input bit mv, input int mh, input int mp, input bit rd, input string tag);
        ftl_valid = fv; ftl_host = HOST_ID_BIT_WIDTH'(fh); ftl_plane = PLANE_ID_BIT_WIDTH'(fp);
        fmc_valid = mv; fmc_host = HOST_ID_BIT_WIDTH'(mh); fmc_plane = PLANE_ID_BIT_WIDTH'(mp);
        rdy = rd;
        @(posedge clk);
        modelStep();
        #1;
        checkAgainstModel(tag);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        ftl_valid = 0; fmc_valid = 0; rdy = 0;
        ftl_host = '0; ftl_plane = '0; fmc_host = '0; fmc_plane = '0;
        modelClear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int got_host[$];
        int got_plane[$];
        int transfers;
        int next_id;

        // Test 1: single FTL request, 2-cycle latency, held for one cycle
        vecs.push_back(mk(1, 1,1,3, 0,0,0, 1,  0,0,0,0, 1,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  1,1,3,0, 0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  0,0,0,0, 0,0));
`ifndef RES_ARB_FMC_PRIORITY_EN
        // Test 2: simultaneous FTL/FMC streams alternate starting with FTL
        vecs.push_back(mk(1, 1,0,0, 1,3,4, 1,  0,0,0,0, 1,1));
        vecs.push_back(mk(0, 1,1,1, 1,2,5, 1,  1,0,0,0, 1,2));
        vecs.push_back(mk(0, 1,2,2, 1,1,6, 1,  1,3,4,1, 2,2));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  1,1,1,0, 1,2));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  1,2,5,1, 1,1));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  1,2,2,0, 0,1));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  1,1,6,1, 0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,  0,0,0,0, 0,0));
`endif

        doReset();
        checkOutput("reset.valid", out_valid, 0);
        checkOutput("reset.ftl_ready", ftl_ready, 1);
        checkOutput("reset.fmc_ready", fmc_ready, 1);
        checkOutput("reset.host", out_host, 0);
        checkOutput("reset.source", out_source, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) doReset();
            applyStimulus(vecs[i].fv, vecs[i].fh, vecs[i].fp, vecs[i].mv, vecs[i].mh, vecs[i].mp,
                          vecs[i].rd, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.tbl_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                checkOutput($sformatf("vec%0d.tbl_host", i), out_host, vecs[i].eh);
                checkOutput($sformatf("vec%0d.tbl_plane", i), out_plane, vecs[i].ep);
                checkOutput($sformatf("vec%0d.tbl_source", i), out_source, vecs[i].es);
            end
            checkOutput($sformatf("vec%0d.tbl_ftl_level", i), ftl_level, vecs[i].efl);
            checkOutput($sformatf("vec%0d.tbl_fmc_level", i), fmc_level, vecs[i].eml);
        end

        // Test 3: back-pressure fills FTL FIFO plus output register; overflow request refused
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, i % 4, i, 0,0,0, 0, "bp_fill");
        checkOutput("bp.ftl_ready", ftl_ready, 0);
        checkOutput("bp.ftl_level", ftl_level, 4);
        applyStimulus(1, 3, 7, 0,0,0, 0, "bp_sixth");
        checkOutput("bp.sixth_level", ftl_level, 4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0,0,0, 0,0,0, 0, "bp_hold");
            checkOutput("bp.hold_host", out_host, 0);
            checkOutput("bp.hold_plane", out_plane, 0);
        end
        for (int c = 0; c < 15; c++) begin
            if (out_valid) begin
                got_host.push_back(int'(out_host));
                got_plane.push_back(int'(out_plane));
            end
            applyStimulus(0,0,0, 0,0,0, 1, "bp_drain");
        end
        checkOutput("bp.drain_count", got_host.size(), 5);
        for (int i = 0; i < got_host.size() && i < 5; i++) begin
            checkOutput($sformatf("bp.drain%0d_host", i), got_host[i], i % 4);
            checkOutput($sformatf("bp.drain%0d_plane", i), got_plane[i], i);
        end

        // Test 4: full FIFO blocks a push in the same cycle as a pop, then wraps over 20 transfers
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, i % 4, i, 0,0,0, 0, "wrap_fill");
        applyStimulus(1, 1, 5, 0,0,0, 1, "wrap_blocked");
        checkOutput("wrap.blocked_level", ftl_level, 3);
        applyStimulus(1, 1, 5, 0,0,0, 1, "wrap_accept");
        checkOutput("wrap.accept_level", ftl_level, 3);
        transfers = 0;
        next_id = 6;
        for (int c = 0; c < 60 && transfers < 20; c++) begin
            bit r;
            r = ($urandom_range(3) != 0);
            if (out_valid && r) transfers++;
            applyStimulus(1, next_id % 4, next_id % 8, 0,0,0, r, "wrap_stream");
            if (ftl_q.size() > 0 && ftl_q[ftl_q.size()-1].plane == next_id % 8) next_id++;
        end
        checkOutput("wrap.transfer_count", transfers >= 20, 1);

        // Test 5: asynchronous reset while holding a request with two more queued
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, i, i + 2, 0,0,0, 0, "rst_fill");
        checkOutput("rst.pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async_valid", out_valid, 0);
        checkOutput("rst.async_ftl_level", ftl_level, 0);
        checkOutput("rst.async_fmc_level", fmc_level, 0);
        checkOutput("rst.async_ftl_ready", ftl_ready, 1);
        modelClear();
        ftl_valid = 0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0,0,0, 0,0,0, 1, "rst_after");

`ifdef RES_ARB_FMC_PRIORITY_EN
        // Test 6: both FIFOs saturated -> FMC x4, FTL, FMC x4, FTL
        begin
            int pattern[10];
            pattern = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
            doReset();
            for (int i = 0; i < 5; i++) applyStimulus(1, i % 4, i, 1, (i + 1) % 4, (i + 3) % 8, 0, "prio_fill");
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("prio.grant%0d", i), out_source, pattern[i]);
                applyStimulus(1, i % 4, i % 8, 1, (i + 2) % 4, (i + 5) % 8, 1, "prio_run");
            end
        end
`endif

        // Random traffic against the reference model
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(2) != 0, $urandom_range(MAX_HOST_NUMBER - 1), $urandom_range(MAX_PLANE_NUMBER - 1),
                          $urandom_range(2) != 0, $urandom_range(MAX_HOST_NUMBER - 1), $urandom_range(MAX_PLANE_NUMBER - 1),
                          $urandom_range(3) != 0, "random");
        end
        for (int c = 0; c < 12; c++) applyStimulus(0,0,0, 0,0,0, 1, "random_drain");
        checkOutput("random.drained_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
